// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction/data register datapath behind the TAP controller.
// It holds IR, BYPASS, IDCODE and USER registers, muxes TDO, and exposes USER to the core.
module jtag_ir_dr_path #(
  parameter int unsigned IR_WIDTH = 4,
  parameter int unsigned DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5071,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] OP_USER = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(4'b1111)
) (
  input  logic                TCK,
  input  logic                reset,
  input  logic                TDI,
  input  logic                select,
  input  logic                enable,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic [DR_WIDTH-1:0] user_din,
  output logic [DR_WIDTH-1:0] user_dout,
  output logic                user_update,
  output logic [IR_WIDTH-1:0] instr,
  output logic                TDO,
  output logic                tdo_en
);

  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic [31:0]         id_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic                sel_id;
  logic                sel_user;

  // Anything that is neither IDCODE nor USER falls through to BYPASS.
  always_comb begin
    sel_id   = (instr == OP_IDCODE);
    sel_user = (instr == OP_USER) && (OP_USER != OP_BYPASS);
  end

  // Instruction register: shift stage and latched instruction.
  always_ff @(posedge TCK) begin
    if (reset) begin
      ir_shift <= '0;
      instr    <= OP_IDCODE;
    end else if (capture_ir) begin
      ir_shift <= IR_WIDTH'(2'b01);
    end else if (shift_ir) begin
      ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
    end else if (update_ir) begin
      instr <= ir_shift;
    end
  end

  // Data registers; only the register selected by the decoded instruction reacts.
  always_ff @(posedge TCK) begin
    if (reset) begin
      bypass_reg  <= 1'b0;
      id_shift    <= '0;
      user_shift  <= '0;
      user_dout   <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (capture_dr) begin
        if (sel_id)        id_shift   <= IDCODE_VALUE;
        else if (sel_user) user_shift <= user_din;
        else               bypass_reg <= 1'b0;
      end else if (shift_dr) begin
        if (sel_id)        id_shift   <= {TDI, id_shift[31:1]};
        else if (sel_user) user_shift <= {TDI, user_shift[DR_WIDTH-1:1]};
        else               bypass_reg <= TDI;
      end else if (update_dr && sel_user) begin
        user_dout   <= user_shift;
        user_update <= 1'b1;
      end
    end
  end

  // Serial output mux.
  always_comb begin
    TDO = bypass_reg;
    if (select)        TDO = ir_shift[0];
    else if (sel_id)   TDO = id_shift[0];
    else if (sel_user) TDO = user_shift[0];
  end

  assign tdo_en = enable;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Self-checking bench for jtag_ir_dr_path: directed scenarios plus random IR/DR scans
// checked against a queue-based model of the scan chains.
module tb_jtag_ir_dr_path;

  localparam logic [31:0] IDCODE = 32'h1234_5071;

  logic       TCK = 1'b0;
  logic       reset = 1'b0;
  logic       TDI = 1'b0;
  logic       select = 1'b0;
  logic       enable = 1'b0;
  logic       capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
  logic       capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic [7:0] user_din = 8'h00;
  logic [7:0] user_dout;
  logic       user_update;
  logic [3:0] instr;
  logic       TDO;
  logic       tdo_en;

  int tests = 0;
  int failed = 0;

  logic [3:0] m_instr;
  logic [7:0] m_dout;

  jtag_ir_dr_path dut (
    .TCK(TCK), .reset(reset), .TDI(TDI), .select(select), .enable(enable),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .user_din(user_din), .user_dout(user_dout), .user_update(user_update),
    .instr(instr), .TDO(TDO), .tdo_en(tdo_en)
  );

  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_instr = 4'b0001;
    m_dout  = 8'h00;
  endtask

  // IR scan: capture, n shifts of data (LSB first), update.
  task automatic ir_scan(input int n, input logic [63:0] data, output logic [63:0] outw);
    bit q[$];
    logic [3:0] v;
    q = {1'b1, 1'b0, 1'b0, 1'b0};
    outw = '0;
    select = 1'b1;
    capture_ir = 1'b1;
    tick();
    capture_ir = 1'b0;
    shift_ir = 1'b1;
    enable = 1'b1;
    check("ir_tdo_en", 32'(tdo_en), 32'd1);
    for (int i = 0; i < n; i++) begin
      TDI = data[i];
      check("ir_tdo", 32'(TDO), 32'(q[0]));
      outw[i] = TDO;
      void'(q.pop_front());
      q.push_back(bit'(data[i]));
      tick();
    end
    shift_ir = 1'b0;
    enable = 1'b0;
    update_ir = 1'b1;
    tick();
    update_ir = 1'b0;
    for (int i = 0; i < 4; i++) v[i] = q[i];
    m_instr = v;
    check("ir_instr", 32'(instr), 32'(m_instr));
  endtask

  // DR scan against whatever register the model's instruction selects.
  task automatic dr_scan(input int n, input logic [63:0] data, input logic [7:0] din,
                         input bit upd, output logic [63:0] outw);
    bit q[$];
    bit is_user;
    q = {};
    outw = '0;
    is_user = (m_instr == 4'b0010);
    if (m_instr == 4'b0001) for (int i = 0; i < 32; i++) q.push_back(bit'(IDCODE[i]));
    else if (is_user)       for (int i = 0; i < 8; i++) q.push_back(bit'(din[i]));
    else                    q.push_back(1'b0);
    select = 1'b0;
    user_din = din;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < n; i++) begin
      TDI = data[i];
      check("dr_tdo", 32'(TDO), 32'(q[0]));
      outw[i] = TDO;
      void'(q.pop_front());
      q.push_back(bit'(data[i]));
      tick();
    end
    shift_dr = 1'b0;
    if (upd) begin
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      if (is_user) begin
        for (int i = 0; i < 8; i++) m_dout[i] = q[i];
        check("user_update_pulse", 32'(user_update), 32'd1);
        tick();
      end
    end
    check("user_update_low", 32'(user_update), 32'd0);
    check("user_dout", 32'(user_dout), 32'(m_dout));
  endtask

  initial begin
    logic [63:0] o;
    m_instr = 4'b0001;
    m_dout  = 8'h00;

    // Reset state and IDCODE readout.
    do_reset();
    check("rst_instr", 32'(instr), 32'h1);
    check("rst_dout", 32'(user_dout), 32'h0);
    check("rst_update", 32'(user_update), 32'h0);
    dr_scan(32, 64'h0, 8'h00, 1'b1, o);
    check("idcode_word", o[31:0], 32'h1234_5071);

    // IR load of USER opcode.
    ir_scan(4, 64'b0010, o);
    check("ir_capture_bits", 32'(o[3:0]), 32'h1);
    check("instr_user", 32'(instr), 32'h2);

    // USER capture/shift/update.
    dr_scan(8, 64'h3C, 8'hA5, 1'b1, o);
    check("user_tdo_word", 32'(o[7:0]), 32'hA5);
    check("user_dout_3c", 32'(user_dout), 32'h3C);

    // BYPASS, explicit and via an unknown opcode.
    ir_scan(4, 64'hF, o);
    dr_scan(4, 64'b1101, 8'h00, 1'b1, o);
    check("bypass_word", 32'(o[3:0]), 32'b1010);
    ir_scan(4, 64'h6, o);
    dr_scan(4, 64'b1101, 8'h00, 1'b1, o);
    check("bypass_unk_word", 32'(o[3:0]), 32'b1010);
    check("bypass_unk_dout", 32'(user_dout), 32'h3C);

    // Reset in the middle of a USER shift aborts it.
    do_reset();
    ir_scan(4, 64'h2, o);
    select = 1'b0;
    user_din = 8'hC3;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 4; i++) begin TDI = 1'b1; tick(); end
    do_reset();
    shift_dr = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_update", 32'(user_update), 32'h0);
      tick();
    end
    check("abort_dout", 32'(user_dout), 32'h0);
    check("abort_instr", 32'(instr), 32'h1);

    // Update without shift, then IR activity leaves user_dout alone.
    ir_scan(4, 64'h2, o);
    dr_scan(0, 64'h0, 8'h5A, 1'b1, o);
    check("noshift_dout", 32'(user_dout), 32'h5A);
    capture_ir = 1'b1; tick(); capture_ir = 1'b0;
    shift_ir = 1'b1; TDI = 1'b1; tick(); tick(); shift_ir = 1'b0;
    check("ir_noise_dout", 32'(user_dout), 32'h5A);
    check("ir_noise_update", 32'(user_update), 32'h0);
    check("ir_noise_instr", 32'(instr), 32'h2);

    // Random scans, including wrap-through lengths.
    for (int it = 0; it < 60; it++) begin
      int kind;
      logic [3:0] op;
      kind = int'($urandom_range(0, 9));
      if (kind < 3) begin
        case ($urandom_range(0, 3))
          0: op = 4'h1;
          1: op = 4'h2;
          2: op = 4'hF;
          default: op = 4'($urandom());
        endcase
        ir_scan(4 + int'($urandom_range(0, 3)) * ((kind == 0) ? 1 : 0),
                {60'($urandom()), op}, o);
      end else if (kind < 9) begin
        dr_scan(int'($urandom_range(0, 40)), {32'($urandom()), 32'($urandom())},
                8'($urandom()), bit'($urandom_range(0, 1)), o);
      end else begin
        do_reset();
        check("rand_rst_instr", 32'(instr), 32'h1);
        check("rand_rst_dout", 32'(user_dout), 32'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
